// File: rtl/log2_msb.sv
// log2_msb -- registered floor-log2 / leading-one position unit.
//
// Reports the index of the most-significant set bit of an unsigned
// WIDTH-bit operand, one cycle after it is accepted. A zero operand has
// no defined log2; it yields log2=0 with the zero flag raised.
//
// Parameters:
//   WIDTH  operand width, power of two, >= 2
//   OUT_W  result width, must equal $clog2(WIDTH)
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand A valid this cycle
//   A          unsigned operand
//   out_valid  registered result corresponds to an accepted operand
//   log2       floor(log2(A)), 0 when A==0
//   zero       accepted operand was 0
//   is_pow2    (only with LOG2_POW2_EN) accepted operand had exactly one bit set
//
// Optional feature macro: LOG2_POW2_EN adds the is_pow2 output.
//
// When in_valid is low, out_valid drops and the result registers hold
// their previous contents.

module log2_msb #(
    parameter int WIDTH = 32,
    parameter int OUT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    output logic             out_valid,
    output logic [OUT_W-1:0] log2,
`ifdef LOG2_POW2_EN
    output logic             is_pow2,
`endif
    output logic             zero
);

    logic             valid_d, valid_q;
    logic [OUT_W-1:0] log2_d,  log2_q;
    logic             zero_d,  zero_q;
    logic [OUT_W-1:0] msb_c;

    // Priority encode: scanning upward lets the highest set bit win.
    always_comb begin
        msb_c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (A[i]) msb_c = OUT_W'(i);
        end
    end

    always_comb begin
        valid_d = in_valid;
        log2_d  = log2_q;
        zero_d  = zero_q;
        // Gate on in_valid so an idle (possibly X) operand never reaches state.
        if (in_valid) begin
            log2_d = msb_c;
            zero_d = (A == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            log2_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            log2_q  <= log2_d;
            zero_q  <= zero_d;
        end
    end

`ifdef LOG2_POW2_EN
    logic pow2_d, pow2_q;

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves 0.
    always_comb begin
        pow2_d = pow2_q;
        if (in_valid) begin
            pow2_d = (A != '0) && ((A & (A - WIDTH'(1))) == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pow2_q <= 1'b0;
        else        pow2_q <= pow2_d;
    end

    assign is_pow2 = pow2_q;
`endif

    assign out_valid = valid_q;
    assign log2      = log2_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_log2_msb.sv
// Testbench for log2_msb: scoreboard of expected results pushed when an
// operand is driven, popped and compared one cycle later.

module tb_log2_msb;

    localparam int WIDTH = 32;
    localparam int OUT_W = 5;

    typedef struct {
        logic [OUT_W-1:0] l;
        logic             z;
        logic             p;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic             out_valid;
    logic [OUT_W-1:0] log2;
    logic             zero;
    logic             is_pow2;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

`ifdef LOG2_POW2_EN
    log2_msb #(.WIDTH(WIDTH), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A),
        .out_valid(out_valid), .log2(log2), .is_pow2(is_pow2), .zero(zero));
`else
    log2_msb #(.WIDTH(WIDTH), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .A(A),
        .out_valid(out_valid), .log2(log2), .zero(zero));
    assign is_pow2 = 1'b0;
`endif

    // Reference: scan downward from the top bit, stop at the first one.
    function automatic exp_t model(input logic [WIDTH-1:0] a);
        exp_t e;
        int   ones;
        e.l  = '0;
        e.z  = (a == 0);
        ones = 0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (a[i]) ones++;
        end
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (a[i]) begin
                e.l = OUT_W'(i);
                break;
            end
        end
        e.p = (ones == 1);
        return e;
    endfunction

    // Drive one cycle; valid operands push their expected result.
    task automatic step(input logic v, input logic [WIDTH-1:0] a);
        in_valid = v;
        A        = a;
        if (v) sb.push_back(model(a));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        A        = 32'hFFFF_FFFF;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b0 || log2 !== '0 || zero !== 1'b0 || is_pow2 !== 1'b0) begin
                errors++;
                $display("FAIL reset cyc%0d: got v=%b l=%0d z=%b p=%b want v=0 l=0 z=0 p=0",
                         c, out_valid, log2, zero, is_pow2);
            end
        end
        rst_n = 1'b1;
        step(1'b1, 32'hFFFF_FFFF);
        begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || log2 !== 5'd31 || log2 !== e.l || zero !== 1'b0) begin
                errors++;
                $display("FAIL reset_release: got v=%b l=%0d z=%b want v=1 l=31 z=0",
                         out_valid, log2, zero);
            end
        end
    endtask

    task automatic test_boundary();
        logic [WIDTH-1:0] ops [11] = '{0, 1, 2, 3, 4, 7, 8, 15, 16, 31, 32};
        logic [OUT_W-1:0] want[11] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5};
        for (int k = 0; k < 11; k++) begin
            exp_t e;
            step(1'b1, ops[k]);
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || log2 !== want[k] || log2 !== e.l ||
                zero !== (ops[k] == 0)) begin
                errors++;
                $display("FAIL boundary A=%0d: got v=%b l=%0d z=%b want v=1 l=%0d z=%b",
                         ops[k], out_valid, log2, zero, want[k], ops[k] == 0);
            end
        end
    endtask

    task automatic test_wide();
        logic [WIDTH-1:0] ops [5] = '{32'd65535, 32'd65536, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [OUT_W-1:0] want[5] = '{15, 16, 30, 31, 31};
        for (int k = 0; k < 5; k++) begin
            exp_t e;
            step(1'b1, ops[k]);
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || log2 !== want[k] || log2 !== e.l || zero !== 1'b0) begin
                errors++;
                $display("FAIL wide A=%h: got v=%b l=%0d z=%b want v=1 l=%0d z=0",
                         ops[k], out_valid, log2, zero, want[k]);
            end
        end
    endtask

    task automatic test_hold();
        exp_t e;
        step(1'b1, 32'h100);
        e = sb.pop_front();
        checks++;
        if (out_valid !== 1'b1 || log2 !== 5'd8 || zero !== 1'b0) begin
            errors++;
            $display("FAIL hold_load: got v=%b l=%0d z=%b want v=1 l=8 z=0", out_valid, log2, zero);
        end
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 32'd5);
            checks++;
            if (out_valid !== 1'b0 || log2 !== 5'd8 || zero !== 1'b0 || sb.size() != 0) begin
                errors++;
                $display("FAIL hold cyc%0d: got v=%b l=%0d z=%b want v=0 l=8 z=0",
                         c, out_valid, log2, zero);
            end
        end
        // Zero flag must also hold through an idle cycle.
        step(1'b1, 32'd0);
        e = sb.pop_front();
        step(1'b0, 32'd9);
        checks++;
        if (out_valid !== 1'b0 || log2 !== e.l || zero !== 1'b1) begin
            errors++;
            $display("FAIL hold_zero: got v=%b l=%0d z=%b want v=0 l=0 z=1", out_valid, log2, zero);
        end
    endtask

    task automatic test_midstream_reset();
        step(1'b1, 32'hFF);
        void'(sb.pop_front());
        in_valid = 1'b1;
        A        = 32'h1234_5678;
        sb.push_back(model(A));
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        checks++;
        if (out_valid !== 1'b0 || log2 !== '0 || zero !== 1'b0 || is_pow2 !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got v=%b l=%0d z=%b p=%b want v=0 l=0 z=0 p=0",
                     out_valid, log2, zero, is_pow2);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || log2 !== '0) begin
            errors++;
            $display("FAIL reset_discard: got v=%b l=%0d want v=0 l=0", out_valid, log2);
        end
        rst_n = 1'b1;
        step(1'b1, 32'd1000);
        begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || log2 !== 5'd9 || log2 !== e.l) begin
                errors++;
                $display("FAIL post_reset: got v=%b l=%0d want v=1 l=9", out_valid, log2);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1000; k++) begin
            logic [WIDTH-1:0] a;
            exp_t e;
            a = $urandom() >> $urandom_range(0, 31);
            if (k % 97 == 0) a = '0;
            step(1'b1, a);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL random_sb_empty k=%0d", k);
            end else begin
                e = sb.pop_front();
                checks++;
                if (out_valid !== 1'b1 || log2 !== e.l || zero !== e.z) begin
                    errors++;
                    $display("FAIL random A=%h: got v=%b l=%0d z=%b want v=1 l=%0d z=%b",
                             a, out_valid, log2, zero, e.l, e.z);
                end
            end
        end
    endtask

`ifdef LOG2_POW2_EN
    task automatic test_pow2();
        logic [WIDTH-1:0] ops [5] = '{32'd64, 32'd96, 32'd0, 32'h8000_0000, 32'd1};
        logic             wp  [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [OUT_W-1:0] wl  [5] = '{6, 6, 0, 31, 0};
        for (int k = 0; k < 5; k++) begin
            exp_t e;
            step(1'b1, ops[k]);
            e = sb.pop_front();
            checks++;
            if (out_valid !== 1'b1 || is_pow2 !== wp[k] || is_pow2 !== e.p ||
                log2 !== wl[k] || zero !== (ops[k] == 0)) begin
                errors++;
                $display("FAIL pow2 A=%0d: got p=%b l=%0d z=%b want p=%b l=%0d z=%b",
                         ops[k], is_pow2, log2, zero, wp[k], wl[k], ops[k] == 0);
            end
        end
        step(1'b0, 32'd3);
        checks++;
        if (out_valid !== 1'b0 || is_pow2 !== 1'b1) begin
            errors++;
            $display("FAIL pow2_hold: got v=%b p=%b want v=0 p=1", out_valid, is_pow2);
        end
    endtask
`endif

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = '0;
        #1;
        test_reset();
        test_boundary();
        test_wide();
        test_hold();
        test_midstream_reset();
        test_random();
`ifdef LOG2_POW2_EN
        test_pow2();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/log2_msb.md
Name: log2_msb

Overview:
- Registered floor-log2 unit: reports the bit index of the most-significant set bit of a WIDTH-bit unsigned operand.
- Sits in datapaths needing leading-one position, e.g. normalisation shift counts and magnitude estimation.
- Single pipeline stage with a valid qualifier; zero input is flagged separately because log2(0) is undefined.

Parameters:
- WIDTH, 32, operand width in bits; must be a power of two, at least 2.
- OUT_W, 5, result width; must equal clog2(WIDTH). 5 for the default width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand A is valid this cycle.
- A  input  WIDTH  unsigned operand.
- out_valid  output  1  registered results correspond to an accepted operand.
- log2  output  OUT_W  floor(log2(A)), i.e. index of highest set bit of A.
- zero  output  1  accepted operand was 0.

Behaviour:
- Reset: rst_n low forces out_valid=0, log2=0 and zero=0 immediately, independent of clk. Deassertion takes effect at the next rising edge.
- Priority encode, combinational: result = largest i with A[i]=1, scanning from WIDTH-1 down to 0. Lower set bits are ignored.
  - Examples: 1->0, 2->1, 3->1, 7->2, 8->3, 32->5, 65535->15, 65536->16, 0x7FFFFFFF->30, 0x80000000->31, 0xFFFFFFFF->31.
- A=0: result=0 and zero=1. For any nonzero A, zero=0.
- Latency: exactly 1 cycle. Operand sampled on edge N while in_valid=1 appears on log2/zero with out_valid=1 after edge N. Full throughput, one result per cycle, no backpressure.
- in_valid=0 at an edge: out_valid goes to 0; log2 and zero hold their previous values.
- Back-to-back valid operands each produce their own result on consecutive cycles, in order.
- Reset asserted mid-stream: any in-flight result is discarded and outputs return to reset values.
- A may contain X only when in_valid=0; no X on outputs after reset.
- No state machine; all outputs are registered.

Optional Feature:
- Macro LOG2_POW2_EN.
- Defined: adds output port is_pow2 (1 bit), registered with the same latency and hold rules as log2. is_pow2=1 iff A is nonzero with exactly one bit set; reset value 0.
- Undefined: port is_pow2 and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with in_valid=1 and A=0xFFFFFFFF -> out_valid=0, log2=0, zero=0 throughout. Release -> first result is 31 one cycle later.
- Boundary operands, one per cycle with in_valid=1: 0,1,2,3,4,7,8,15,16,31,32 -> log2 = 0,0,1,1,2,2,3,3,4,4,5 each one cycle later; zero=1 only for A=0.
- Wide operands: 65535, 65536, 0x7FFFFFFF, 0x80000000, 0xFFFFFFFF -> 15, 16, 30, 31, 31.
- Hold: A=0x100 valid, then in_valid=0 for 2 cycles with A=5 -> log2 stays 8 with out_valid=0.
- Random: 1000 random A values back-to-back -> each result matches a reference MSB scan and zero flag.
- With LOG2_POW2_EN: A=64 -> is_pow2=1, log2=6. A=96 -> is_pow2=0, log2=6. A=0 -> is_pow2=0, zero=1.
